pipe_hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage 16-bit CPU. It watches register numbers and write enables in ID, EX, MEM and WB and drives the stall and flush controls for the IF/ID and ID/EX pipeline registers. It generates operand-forwarding selects for EX and sequences multi-cycle load-use stalls, memory-busy freezes and halt. It sits beside the pipeline registers and is the only source of their stall and flush controls.

---
 rtl/cpu_pipe_pkg.sv | 26 ++
 rtl/fwd_select.sv | 23 ++
 rtl/pipe_hazard_ctrl.sv | 139 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared types for the 16-bit CPU pipeline control: hazard FSM states,
// forwarding selects and the register-number width.
`timescale 1ns/1ps
package cpu_pipe_pkg;

    localparam int REGNUM_W = 3;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        HALT    = 2'd2
    } hz_state_t;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

    // True when an instruction that really reads src_num depends on the writer.
    function automatic logic reg_dep(input logic uses, input logic [REGNUM_W-1:0] src_num,
                                     input logic [REGNUM_W-1:0] dst_num);
        return uses && (src_num == dst_num);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Operand forwarding comparator for one EX source operand; MEM wins over WB.
`timescale 1ns/1ps
module fwd_select
    import cpu_pipe_pkg::*;
(
    input  logic [REGNUM_W-1:0] src_num,
    input  logic [REGNUM_W-1:0] mem_rd_num,
    input  logic                mem_write,
    input  logic [REGNUM_W-1:0] wb_rd_num,
    input  logic                wb_write,
    output fwd_sel_t            sel
);

    always_comb begin
        sel = FWD_REG;
        if (mem_write && (mem_rd_num == src_num)) begin
            sel = FWD_MEM;
        end else if (wb_write && (wb_rd_num == src_num)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller: stall/flush for IF/ID and ID/EX, load-use bubble sequencing,
// memory-busy freeze, halt, EX forwarding selects and saturating perf counters.
`timescale 1ns/1ps
module pipe_hazard_ctrl
    import cpu_pipe_pkg::*;
#(
    parameter int LOAD_USE_STALLS = 1,
    parameter int CNT_W           = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [REGNUM_W-1:0] idRnNum,
    input  logic [REGNUM_W-1:0] idRmNum,
    input  logic                idUsesRn,
    input  logic                idUsesRm,
    input  logic [REGNUM_W-1:0] exRnNum,
    input  logic [REGNUM_W-1:0] exRmNum,
    input  logic [REGNUM_W-1:0] exRdNum,
    input  logic                exWrite,
    input  logic                exIsLoad,
    input  logic                branchTakenE,
    input  logic                haltE,
    input  logic [REGNUM_W-1:0] memRdNum,
    input  logic                memWrite,
    input  logic                memBusy,
    input  logic [REGNUM_W-1:0] wbRdNum,
    input  logic                wbWrite,
    output logic                stallF,
    output logic                stallD,
    output logic                stallE,
    output logic                flushD,
    output logic                flushE,
    output fwd_sel_t            fwdA,
    output fwd_sel_t            fwdB,
    output logic                halted,
    output logic [CNT_W-1:0]    stallCycles,
    output logic [CNT_W-1:0]    flushCount,
    output hz_state_t           dbg_state
);

    // The first bubble is issued from RUN, so LDSTALL covers the remaining ones.
    localparam logic [3:0] LD_INIT = (LOAD_USE_STALLS > 1) ? 4'(LOAD_USE_STALLS - 2) : 4'd0;

    hz_state_t  state, nxt_state;
    logic [3:0] ld_cnt, nxt_cnt;
    logic       stall_f, stall_d, stall_e, flush_d, flush_e;
    logic       load_use;
    fwd_sel_t   fwd_a, fwd_b;

    assign load_use = exIsLoad && exWrite &&
                      (reg_dep(idUsesRn, idRnNum, exRdNum) || reg_dep(idUsesRm, idRmNum, exRdNum));

    always_comb begin
        stall_f   = 1'b0;
        stall_d   = 1'b0;
        stall_e   = 1'b0;
        flush_d   = 1'b0;
        flush_e   = 1'b0;
        nxt_state = state;
        nxt_cnt   = ld_cnt;
        if (state == HALT) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end else if (haltE) begin
            stall_f   = 1'b1;
            stall_d   = 1'b1;
            flush_e   = 1'b1;
            nxt_state = HALT;
        end else if (memBusy) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
        end else if (branchTakenE) begin
            flush_d   = 1'b1;
            flush_e   = 1'b1;
            nxt_state = RUN;
        end else if (state == LDSTALL) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
            if (ld_cnt == 4'd0) nxt_state = RUN;
            else                nxt_cnt   = ld_cnt - 4'd1;
        end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
            if (LOAD_USE_STALLS > 1) begin
                nxt_state = LDSTALL;
                nxt_cnt   = LD_INIT;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            ld_cnt      <= 4'd0;
            stallCycles <= '0;
            flushCount  <= '0;
        end else begin
            state  <= nxt_state;
            ld_cnt <= nxt_cnt;
            if (stall_d && (stallCycles != '1)) stallCycles <= stallCycles + CNT_W'(1);
            if ((flush_d || flush_e) && !memBusy && (flushCount != '1))
                flushCount <= flushCount + CNT_W'(1);
        end
    end

    fwd_select u_fwd_rn (
        .src_num    (exRnNum),
        .mem_rd_num (memRdNum),
        .mem_write  (memWrite),
        .wb_rd_num  (wbRdNum),
        .wb_write   (wbWrite),
        .sel        (fwd_a)
    );

    fwd_select u_fwd_rm (
        .src_num    (exRmNum),
        .mem_rd_num (memRdNum),
        .mem_write  (memWrite),
        .wb_rd_num  (wbRdNum),
        .wb_write   (wbWrite),
        .sel        (fwd_b)
    );

    // Outputs are forced quiet while reset is held, independent of the inputs.
    assign stallF    = stall_f & ~reset;
    assign stallD    = stall_d & ~reset;
    assign stallE    = stall_e & ~reset;
    assign flushD    = flush_d & ~reset;
    assign flushE    = flush_e & ~reset;
    assign fwdA      = reset ? FWD_REG : fwd_a;
    assign fwdB      = reset ? FWD_REG : fwd_b;
    assign halted    = (state == HALT);
    assign dbg_state = state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: three instances (1, 3 and 4 load-use bubbles; the last
// with 4-bit counters) share one stimulus bus; each vector names the instance it checks.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;
  import cpu_pipe_pkg::*;

  localparam int EW = 46;

  typedef struct packed {
    logic       rst;
    logic [2:0] id_rn;
    logic [2:0] id_rm;
    logic       use_rn;
    logic       use_rm;
    logic [2:0] ex_rn;
    logic [2:0] ex_rm;
    logic [2:0] ex_rd;
    logic       ex_wr;
    logic       ex_ld;
    logic       br;
    logic       hlt;
    logic [2:0] mem_rd;
    logic       mem_wr;
    logic       busy;
    logic [2:0] wb_rd;
    logic       wb_wr;
  } stim_t;

  // Observed controls of one instance, in the same order as the expected word.
  typedef struct packed {
    logic       sf;
    logic       sd;
    logic       se;
    logic       fd;
    logic       fe;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       h;
    logic [1:0] st;
  } obs_t;

  localparam logic [4:0] C0     = 5'b00000;
  localparam logic [4:0] C_LDU  = 5'b11001;
  localparam logic [4:0] C_HLT  = 5'b11001;
  localparam logic [4:0] C_BUSY = 5'b11100;
  localparam logic [4:0] C_BR   = 5'b00011;
  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_LDS  = 2'd1;
  localparam logic [1:0] S_HLT  = 2'd2;

  logic  clk = 1'b0;
  stim_t s;
  stim_t drv;
  logic  vld = 1'b0;
  obs_t  o0, o1, o2;
  logic [15:0] sc0, fc0, sc1, fc1;
  logic [3:0]  sc2, fc2;

  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  int            n_chk = 0;
  int            n_fail = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    drv     = '0;
    drv.rst = 1'b1;
  end

  // ---------------- DUTs ----------------
  pipe_hazard_ctrl #(.LOAD_USE_STALLS(1), .CNT_W(16)) u_l1 (
    .clk(clk), .reset(drv.rst),
    .idRnNum(drv.id_rn), .idRmNum(drv.id_rm), .idUsesRn(drv.use_rn), .idUsesRm(drv.use_rm),
    .exRnNum(drv.ex_rn), .exRmNum(drv.ex_rm), .exRdNum(drv.ex_rd),
    .exWrite(drv.ex_wr), .exIsLoad(drv.ex_ld), .branchTakenE(drv.br), .haltE(drv.hlt),
    .memRdNum(drv.mem_rd), .memWrite(drv.mem_wr), .memBusy(drv.busy),
    .wbRdNum(drv.wb_rd), .wbWrite(drv.wb_wr),
    .stallF(o0.sf), .stallD(o0.sd), .stallE(o0.se), .flushD(o0.fd), .flushE(o0.fe),
    .fwdA(o0.fa), .fwdB(o0.fb), .halted(o0.h),
    .stallCycles(sc0), .flushCount(fc0), .dbg_state(o0.st)
  );

  pipe_hazard_ctrl #(.LOAD_USE_STALLS(3), .CNT_W(16)) u_l3 (
    .clk(clk), .reset(drv.rst),
    .idRnNum(drv.id_rn), .idRmNum(drv.id_rm), .idUsesRn(drv.use_rn), .idUsesRm(drv.use_rm),
    .exRnNum(drv.ex_rn), .exRmNum(drv.ex_rm), .exRdNum(drv.ex_rd),
    .exWrite(drv.ex_wr), .exIsLoad(drv.ex_ld), .branchTakenE(drv.br), .haltE(drv.hlt),
    .memRdNum(drv.mem_rd), .memWrite(drv.mem_wr), .memBusy(drv.busy),
    .wbRdNum(drv.wb_rd), .wbWrite(drv.wb_wr),
    .stallF(o1.sf), .stallD(o1.sd), .stallE(o1.se), .flushD(o1.fd), .flushE(o1.fe),
    .fwdA(o1.fa), .fwdB(o1.fb), .halted(o1.h),
    .stallCycles(sc1), .flushCount(fc1), .dbg_state(o1.st)
  );

  pipe_hazard_ctrl #(.LOAD_USE_STALLS(4), .CNT_W(4)) u_l4 (
    .clk(clk), .reset(drv.rst),
    .idRnNum(drv.id_rn), .idRmNum(drv.id_rm), .idUsesRn(drv.use_rn), .idUsesRm(drv.use_rm),
    .exRnNum(drv.ex_rn), .exRmNum(drv.ex_rm), .exRdNum(drv.ex_rd),
    .exWrite(drv.ex_wr), .exIsLoad(drv.ex_ld), .branchTakenE(drv.br), .haltE(drv.hlt),
    .memRdNum(drv.mem_rd), .memWrite(drv.mem_wr), .memBusy(drv.busy),
    .wbRdNum(drv.wb_rd), .wbWrite(drv.wb_wr),
    .stallF(o2.sf), .stallD(o2.sd), .stallE(o2.se), .flushD(o2.fd), .flushE(o2.fe),
    .fwdA(o2.fa), .fwdB(o2.fb), .halted(o2.h),
    .stallCycles(sc2), .flushCount(fc2), .dbg_state(o2.st)
  );

  // ---------------- driver ----------------
  // Applies the staged stimulus s just after a rising edge and queues the expectation
  // for that cycle: {instance, stallF/D/E, flushD/E, fwdA, fwdB, halted, state, counters}.
  task automatic cyc(input string nm, input bit chk, input logic [1:0] sel,
                     input logic [4:0] ctl, input logic [1:0] fa, input logic [1:0] fb,
                     input logic h, input logic [1:0] st, input int sc, input int fc);
    @(posedge clk);
    #1;
    drv = s;
    vld = chk;
    if (chk) begin
      exp_q.push_back({sel, ctl, fa, fb, h, st, 16'(sc), 16'(fc)});
      name_q.push_back(nm);
    end
  endtask

  function automatic string fmt(input logic [EW-1:0] w);
    return $sformatf("dut=%0d ctl(sF,sD,sE,fD,fE)=%b fwdA=%b fwdB=%b halted=%b state=%0d stallCycles=%0d flushCount=%0d",
                     w[45:44], w[43:39], w[38:37], w[36:35], w[34], w[33:32], w[31:16], w[15:0]);
  endfunction

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (vld) begin
      logic [EW-1:0] e;
      logic [EW-1:0] act;
      string         nm;
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_underflow: got an observation with no expected entry");
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        case (e[45:44])
          2'd0:    act = {e[45:44], o0, sc0, fc0};
          2'd1:    act = {e[45:44], o1, sc1, fc1};
          default: act = {e[45:44], o2, 12'd0, sc2, 12'd0, fc2};
        endcase
        if (act !== e) begin
          n_fail++;
          $display("FAIL %s: got %s ; expected %s", nm, fmt(act), fmt(e));
        end
      end
    end
  end

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached before the stimulus ended");
    summary();
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic set_hazard_rn();
    s        = '0;
    s.ex_rd  = 3'd3;
    s.ex_ld  = 1'b1;
    s.ex_wr  = 1'b1;
    s.id_rn  = 3'd3;
    s.use_rn = 1'b1;
  endtask

  task automatic do_reset(input string nm, input logic [1:0] sel);
    s     = '0;
    s.rst = 1'b1;
    cyc(nm, 1, sel, C0, 2'b00, 2'b00, 1'b0, S_RUN, 0, 0);
  endtask

  initial begin
    s = '0;
    s.rst = 1'b1;
    repeat (2) @(posedge clk);

    // One-bubble load-use, Rn and Rm paths, qualifiers.
    do_reset("reset_l1", 2'd0);
    set_hazard_rn();
    cyc("ldu_rn_l1", 1, 0, C_LDU, 2'b00, 2'b00, 1'b0, S_RUN, 0, 0);
    s = '0;
    cyc("ldu_done_l1", 1, 0, C0, 2'b00, 2'b00, 1'b0, S_RUN, 1, 1);
    set_hazard_rn();
    s.use_rn = 1'b0;
    s.use_rm = 1'b1;
    s.id_rm  = 3'd2;
    cyc("ldu_rn_unused", 1, 0, C0, 2'b00, 2'b00, 1'b0, S_RUN, 1, 1);
    s.id_rm = 3'd3;
    cyc("ldu_rm_l1", 1, 0, C_LDU, 2'b00, 2'b00, 1'b0, S_RUN, 1, 1);
    s.ex_wr = 1'b0;
    cyc("ldu_no_write", 1, 0, C0, 2'b00, 2'b00, 1'b0, S_RUN, 2, 2);

    // Forwarding.
    s = '0;
    s.mem_wr = 1'b1; s.mem_rd = 3'd5; s.wb_wr = 1'b1; s.wb_rd = 3'd5;
    s.ex_rn  = 3'd5; s.ex_rm  = 3'd5;
    cyc("fwd_mem_prio", 1, 0, C0, 2'b01, 2'b01, 1'b0, S_RUN, 2, 2);
    s.mem_wr = 1'b0;
    cyc("fwd_wb", 1, 0, C0, 2'b10, 2'b10, 1'b0, S_RUN, 2, 2);
    s.mem_wr = 1'b1; s.wb_rd = 3'd2; s.ex_rm = 3'd2;
    cyc("fwd_mixed", 1, 0, C0, 2'b01, 2'b10, 1'b0, S_RUN, 2, 2);
    s = '0;
    s.wb_wr = 1'b1; s.wb_rd = 3'd0; s.ex_rn = 3'd0; s.ex_rm = 3'd1;
    cyc("fwd_r0", 1, 0, C0, 2'b10, 2'b00, 1'b0, S_RUN, 2, 2);

    // Three bubbles with a two-cycle memory-busy freeze in the middle.
    do_reset("reset_l3", 2'd1);
    set_hazard_rn();
    cyc("l3_bubble1", 1, 1, C_LDU, 2'b00, 2'b00, 1'b0, S_RUN, 0, 0);
    s = '0;
    s.busy = 1'b1;
    cyc("l3_busy1", 1, 1, C_BUSY, 2'b00, 2'b00, 1'b0, S_LDS, 1, 1);
    cyc("l3_busy2", 1, 1, C_BUSY, 2'b00, 2'b00, 1'b0, S_LDS, 2, 1);
    s.busy = 1'b0;
    cyc("l3_bubble2", 1, 1, C_LDU, 2'b00, 2'b00, 1'b0, S_LDS, 3, 1);
    cyc("l3_bubble3", 1, 1, C_LDU, 2'b00, 2'b00, 1'b0, S_LDS, 4, 2);
    s.ex_rn = 3'd3; s.wb_wr = 1'b1; s.wb_rd = 3'd3;
    cyc("l3_dep_fwd_wb", 1, 1, C0, 2'b10, 2'b00, 1'b0, S_RUN, 5, 3);

    // Branch aborts LDSTALL of a four-bubble hazard.
    do_reset("reset_l4", 2'd2);
    set_hazard_rn();
    cyc("l4_bubble1", 1, 2, C_LDU, 2'b00, 2'b00, 1'b0, S_RUN, 0, 0);
    s = '0;
    cyc("l4_bubble2", 1, 2, C_LDU, 2'b00, 2'b00, 1'b0, S_LDS, 1, 1);
    s.br = 1'b1;
    cyc("l4_branch_abort", 1, 2, C_BR, 2'b00, 2'b00, 1'b0, S_LDS, 2, 2);
    s = '0;
    cyc("l4_back_to_run", 1, 2, C0, 2'b00, 2'b00, 1'b0, S_RUN, 2, 3);

    // Halt beats memBusy, holds, and only an asynchronous reset leaves it.
    do_reset("reset_halt", 2'd2);
    s.rst = 1'b0; s.hlt = 1'b1; s.busy = 1'b1;
    cyc("halt_with_busy", 1, 2, C_HLT, 2'b00, 2'b00, 1'b0, S_RUN, 0, 0);
    s = '0;
    cyc("halted_1", 1, 2, C_HLT, 2'b00, 2'b00, 1'b1, S_HLT, 1, 0);
    cyc("halted_2", 1, 2, C_HLT, 2'b00, 2'b00, 1'b1, S_HLT, 2, 1);
    s.busy = 1'b1; s.br = 1'b1;
    cyc("halted_ignores_br", 1, 2, C_HLT, 2'b00, 2'b00, 1'b1, S_HLT, 3, 2);
    s.rst = 1'b1; s.hlt = 1'b1; s.wb_wr = 1'b1;
    cyc("async_reset_in_halt", 1, 2, C0, 2'b00, 2'b00, 1'b0, S_RUN, 0, 0);
    s = '0;
    cyc("after_reset", 1, 2, C0, 2'b00, 2'b00, 1'b0, S_RUN, 0, 0);

    // Counter saturation: 19 stalled cycles on 4-bit counters.
    s = '0;
    s.busy = 1'b1;
    for (int i = 0; i < 19; i++) begin
      cyc($sformatf("sat_%0d", i), 1, 2, C_BUSY, 2'b00, 2'b00, 1'b0, S_RUN, (i > 15) ? 15 : i, 0);
    end
    s = '0;
    cyc("sat_hold", 1, 2, C0, 2'b00, 2'b00, 1'b0, S_RUN, 15, 0);

    s = '0;
    cyc("idle", 0, 0, C0, 2'b00, 2'b00, 1'b0, S_RUN, 0, 0);
    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
    end
    summary();
    $finish;
  end

endmodule
